// File: rtl/square_pkg.sv
// Shared types and default widths for the sequential squarer.
package square_pkg;

    localparam int SQ_IN_W  = 11;
    localparam int SQ_SAT_W = 21;

    typedef enum logic [1:0] {
        SQ_IDLE,
        SQ_CALC,
        SQ_DONE
    } sq_state_t;

endpackage

// File: rtl/square_seq_dp.sv
// Shift-and-add datapath for square_seq: operand/multiplier/accumulator/count registers plus result register.
// Optional clamp of the committed result to SAT_W bits when SQUARE_SAT_EN is defined.
module square_seq_dp
    import square_pkg::*;
#(
    parameter int IN_W  = SQ_IN_W,
    parameter int SAT_W = SQ_SAT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              commit_i,
    input  logic [IN_W-1:0]   x_i,
    output logic              last_o,
    output logic [2*IN_W-1:0] y_o,
    output logic              sat_o
);

    localparam int PW = 2 * IN_W;
    localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;

    if (SAT_W > PW) begin : g_bad_sat_w
        $error("square_seq_dp: SAT_W must not exceed 2*IN_W");
    end

    logic [IN_W-1:0] a_q;
    logic [IN_W-1:0] m_q;
    logic [PW-1:0]   acc_q;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   y_q;

    logic [PW-1:0]   addend;
    logic [PW-1:0]   acc_d;
    logic [PW-1:0]   y_d;
    logic            sat_d;

    assign last_o = (cnt_q == CW'(IN_W - 1));

    always_comb begin
        addend = '0;
        if (m_q[0]) begin
            addend = {{IN_W{1'b0}}, a_q} << cnt_q;
        end
        acc_d = acc_q + addend;
`ifdef SQUARE_SAT_EN
        sat_d = (acc_d > ~({PW{1'b1}} << SAT_W));
        y_d   = sat_d ? ~({PW{1'b1}} << SAT_W) : acc_d;
`else
        sat_d = 1'b0;
        y_d   = acc_d;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            m_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            y_q   <= '0;
        end else if (load_i) begin
            a_q   <= x_i;
            m_q   <= x_i;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (step_i) begin
            acc_q <= acc_d;
            m_q   <= m_q >> 1;
            cnt_q <= cnt_q + CW'(1);
            if (commit_i) begin
                y_q <= y_d;
            end
        end
    end

`ifdef SQUARE_SAT_EN
    logic sat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else if (step_i && commit_i) begin
            sat_q <= sat_d;
        end
    end

    assign sat_o = sat_q;
`else
    // Flag is constant without the clamp; sat_d folds away.
    assign sat_o = 1'b0;
`endif

    assign y_o = y_q;

endmodule

// File: rtl/square_seq.sv
// Sequential squarer y = x*x, one multiplier bit per clock, valid/ready on both sides, one op in flight.
// Build macro SQUARE_SAT_EN clamps y to SAT_W bits and raises sat.
module square_seq
    import square_pkg::*;
#(
    parameter int IN_W  = SQ_IN_W,
    parameter int SAT_W = SQ_SAT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*IN_W-1:0] y,
    output logic              sat
);

    sq_state_t state_q;
    logic      in_ready_q;
    logic      out_valid_q;

    logic      load;
    logic      step;
    logic      commit;
    logic      last;

    assign load   = (state_q == SQ_IDLE) && in_valid;
    assign step   = (state_q == SQ_CALC);
    assign commit = step && last;

    // in_ready comes from a register, so the DONE-exit cycle can never accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SQ_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                SQ_IDLE: begin
                    if (in_valid) begin
                        state_q    <= SQ_CALC;
                        in_ready_q <= 1'b0;
                    end
                end
                SQ_CALC: begin
                    if (last) begin
                        state_q     <= SQ_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                SQ_DONE: begin
                    if (out_ready) begin
                        state_q     <= SQ_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= SQ_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    square_seq_dp #(
        .IN_W  (IN_W),
        .SAT_W (SAT_W)
    ) u_dp (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load),
        .step_i   (step),
        .commit_i (commit),
        .x_i      (x),
        .last_o   (last),
        .y_o      (y),
        .sat_o    (sat)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_square_seq.sv
// Self-checking bench for square_seq: directed vector table, reset abort, randomized ops vs. arithmetic model.
// Build with SQUARE_SAT_EN defined to check the clamped variant.
module tb_square_seq;

    localparam int IN_W  = 11;
    localparam int SAT_W = 21;
`ifdef SQUARE_SAT_EN
    localparam bit SAT_ON = 1'b1;
`else
    localparam bit SAT_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   x;
    logic              out_valid;
    logic              out_ready;
    logic [2*IN_W-1:0] y;
    logic              sat;

    int checks   = 0;
    int failures = 0;

    square_seq #(.IN_W(IN_W), .SAT_W(SAT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IN_W-1:0]   x;
        int                hold;
        bit                garbage;
        logic [2*IN_W-1:0] y;
        bit                sat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: plain integer square, clamped to 2^SAT_W-1 when the feature is built in.
    task automatic model(input logic [IN_W-1:0] xv, output logic [2*IN_W-1:0] ey, output bit es);
        longint unsigned sq;
        longint unsigned lim;
        sq  = longint'(xv) * longint'(xv);
        lim = (64'd1 << SAT_W) - 64'd1;
        es  = SAT_ON && (sq > lim);
        ey  = es ? (2*IN_W)'(lim) : (2*IN_W)'(sq);
    endtask

    // Entered and left at a negedge with the DUT idle.
    task automatic run_op(input logic [IN_W-1:0] xv, input int hold, input bit garbage,
                          input logic [2*IN_W-1:0] ey, input bit es, input string tag);
        int lat;
        bit rdy_bad;
        bit hold_bad;
        logic [2*IN_W-1:0] yh;
        chk({tag, "_idle_rdy"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        x         = xv;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        lat      = 0;
        rdy_bad  = 1'b0;
        in_valid = garbage ? 1'($urandom_range(0, 1)) : 1'b0;
        x        = garbage ? IN_W'($urandom) : xv;
        while (!out_valid && lat < 40) begin
            if (in_ready) rdy_bad = 1'b1;
            out_ready = garbage ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            lat++;
            if (garbage) begin
                in_valid = 1'($urandom_range(0, 1));
                x        = IN_W'($urandom);
            end
        end
        out_ready = 1'b0;
        chk({tag, "_latency"}, 64'(lat), 64'd11);
        chk({tag, "_rdy_low_calc"}, 64'(rdy_bad | in_ready), 64'd0);
        chk({tag, "_y"}, 64'(y), 64'(ey));
        chk({tag, "_sat"}, 64'(sat), 64'(es));
        yh       = y;
        hold_bad = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            if (!out_valid || in_ready || y !== yh || sat !== es) hold_bad = 1'b1;
            if (garbage) begin
                in_valid = 1'($urandom_range(0, 1));
                x        = IN_W'($urandom);
            end
        end
        chk({tag, "_hold_stable"}, 64'(hold_bad), 64'd0);
        out_ready = 1'b1;
        in_valid  = garbage;
        x         = IN_W'($urandom);
        @(negedge clk);
        chk({tag, "_exit_vld"}, 64'(out_valid), 64'd0);
        chk({tag, "_exit_rdy"}, 64'(in_ready), 64'd1);
        chk({tag, "_exit_y_held"}, 64'(y), 64'(yh));
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    initial begin
        logic [2*IN_W-1:0] ey;
        bit                es;
        bit                spurious;

        vecs[0] = '{11'd5,    0,  1'b0, 22'd25,      1'b0};
        vecs[1] = '{11'd0,    0,  1'b0, 22'd0,       1'b0};
        vecs[2] = '{11'd2047, 0,  1'b0, SAT_ON ? 22'd2097151 : 22'd4190209, SAT_ON};
        vecs[3] = '{11'd300,  20, 1'b0, 22'd90000,   1'b0};
        vecs[4] = '{11'd1448, 1,  1'b0, 22'd2096704, 1'b0};
        vecs[5] = '{11'd1449, 0,  1'b1, SAT_ON ? 22'd2097151 : 22'd2099601, SAT_ON};
        vecs[6] = '{11'd1,    2,  1'b1, 22'd1,       1'b0};
        vecs[7] = '{11'd1024, 3,  1'b1, 22'd1048576, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = '0;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_y", 64'(y), 64'd0);
        chk("reset_sat", 64'(sat), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].x, vecs[i].hold, vecs[i].garbage, vecs[i].y, vecs[i].sat,
                   $sformatf("vec%0d", i));
        end

        // Abort mid-calculation: reset clears outputs immediately and no result appears.
        in_valid = 1'b1;
        x        = 11'd1000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_y", 64'(y), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_sat", 64'(sat), 64'd0);
        @(negedge clk);
        rst      = 1'b0;
        spurious = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid || !in_ready) spurious = 1'b1;
        end
        chk("abort_no_result", 64'(spurious), 64'd0);
        run_op(11'd3, 0, 1'b0, 22'd9, 1'b0, "post_abort");

        for (int i = 0; i < 40; i++) begin
            logic [IN_W-1:0] rx;
            rx = (i % 5 == 0) ? IN_W'($urandom_range(1440, 1460)) : IN_W'($urandom);
            model(rx, ey, es);
            run_op(rx, $urandom_range(0, 3), 1'($urandom_range(0, 1)), ey, es,
                   $sformatf("rnd%0d_x%0d", i, rx));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
